// File: rtl/pong_goal_scorer.sv
`default_nettype none
// ============================================================================
// Module      : pong_goal_scorer
// Description : Per-frame goal detector and score sequencer for pong. Emits
//               per-player score strobes, tracks saturating scores and runs
//               the serve / hold-off / game-over sequence.
//               Optional feature macro: AUTO_SERVE_EN (re-serve on hold-off
//               expiry instead of waiting for a serve button edge).
// Revision    : 1.0 - initial release
// ============================================================================
module pong_goal_scorer #(
    parameter int X_WIDTH        = 10,
    parameter int LEFT_GOAL_X    = 0,
    parameter int RIGHT_GOAL_X   = 639,
    parameter int PULSE_CYCLES   = 4,
    parameter int HOLDOFF_FRAMES = 60,
    parameter int MAX_SCORE      = 5
) (
    input  logic               cloco,
    input  logic               rset,
    input  logic               frame_tick,
    input  logic               ball_valid,
    input  logic [X_WIDTH-1:0] ball_x,
    input  logic               serve_btn,
    output logic               scr_l,
    output logic               scr_r,
    output logic               serve,
    output logic               serve_dir,
    output logic [2:0]         score_l,
    output logic [2:0]         score_r,
    output logic               game_over,
    output logic               winner
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_PLAY    = 3'd1;
    localparam logic [2:0] c_PULSE   = 3'd2;
    localparam logic [2:0] c_HOLDOFF = 3'd3;
    localparam logic [2:0] c_OVER    = 3'd4;

    localparam int c_PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam int c_HW = (HOLDOFF_FRAMES > 1) ? $clog2(HOLDOFF_FRAMES) : 1;

    localparam logic [c_PW-1:0]    c_PLAST   = c_PW'(PULSE_CYCLES - 1);
    localparam logic [c_PW-1:0]    c_PONE    = c_PW'(1);
    localparam logic [c_HW-1:0]    c_HLAST   = c_HW'((HOLDOFF_FRAMES > 0) ? HOLDOFF_FRAMES - 1 : 0);
    localparam logic [c_HW-1:0]    c_HONE    = c_HW'(1);
    localparam logic [X_WIDTH-1:0] c_LEFT_X  = X_WIDTH'(LEFT_GOAL_X);
    localparam logic [X_WIDTH-1:0] c_RIGHT_X = X_WIDTH'(RIGHT_GOAL_X);
    localparam logic [2:0]         c_MAX     = 3'(MAX_SCORE);

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic            r_btn_q;
    logic            r_serve;
    logic            r_serve_dir;
    logic            r_scorer;      // 0 = left player scored, 1 = right player scored
    logic [2:0]      r_score_l;
    logic [2:0]      r_score_r;
    logic [c_PW-1:0] r_pcnt;
    logic [c_HW-1:0] r_hcnt;

    logic            w_btn_rise;
    logic            w_hit_left;
    logic            w_hit_right;
    logic            w_goal;
    logic            w_pulse_done;
    logic            w_hold_done;
    logic            w_serve_set;
    logic [2:0]      w_scorer_score;

    assign w_btn_rise     = serve_btn & ~r_btn_q;
    assign w_hit_left     = (ball_x <= c_LEFT_X);
    assign w_hit_right    = (ball_x >= c_RIGHT_X);
    assign w_goal         = frame_tick & ball_valid & (w_hit_left | w_hit_right);
    assign w_pulse_done   = (r_pcnt == c_PLAST);
    assign w_scorer_score = r_scorer ? r_score_r : r_score_l;

    // A zero-length hold-off expires on its first cycle regardless of frame_tick.
    always_comb begin
        w_hold_done = 1'b0;
        if (HOLDOFF_FRAMES == 0) begin
            w_hold_done = 1'b1;
        end else begin
            w_hold_done = frame_tick && (r_hcnt == c_HLAST);
        end
    end

    always_ff @(posedge cloco or posedge rset) begin
        if (rset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_serve_set = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_btn_rise) begin
                    w_state_nxt = c_PLAY;
                    w_serve_set = 1'b1;
                end
            end
            c_PLAY: begin
                if (w_goal) begin
                    w_state_nxt = c_PULSE;
                end
            end
            c_PULSE: begin
                if (w_pulse_done) begin
                    w_state_nxt = (w_scorer_score >= c_MAX) ? c_OVER : c_HOLDOFF;
                end
            end
            c_HOLDOFF: begin
                if (w_hold_done) begin
`ifdef AUTO_SERVE_EN
                    w_state_nxt = c_PLAY;
                    w_serve_set = 1'b1;
`else
                    w_state_nxt = c_IDLE;
`endif
                end
            end
            c_OVER: begin
                w_state_nxt = c_OVER;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge cloco or posedge rset) begin
        if (rset) begin
            r_btn_q     <= 1'b0;
            r_serve     <= 1'b0;
            r_serve_dir <= 1'b0;
            r_scorer    <= 1'b0;
            r_score_l   <= 3'd0;
            r_score_r   <= 3'd0;
            r_pcnt      <= '0;
            r_hcnt      <= '0;
        end else begin
            r_btn_q <= serve_btn;
            r_serve <= w_serve_set;

            // Left-wall test has priority if both goal windows overlap.
            if ((r_state == c_PLAY) && w_goal) begin
                r_pcnt <= '0;
                if (w_hit_left) begin
                    r_scorer    <= 1'b1;
                    r_serve_dir <= 1'b0;
                    if (r_score_r < c_MAX) begin
                        r_score_r <= r_score_r + 3'd1;
                    end
                end else begin
                    r_scorer    <= 1'b0;
                    r_serve_dir <= 1'b1;
                    if (r_score_l < c_MAX) begin
                        r_score_l <= r_score_l + 3'd1;
                    end
                end
            end else if ((r_state == c_PULSE) && !w_pulse_done) begin
                r_pcnt <= r_pcnt + c_PONE;
            end

            if (r_state != c_HOLDOFF) begin
                r_hcnt <= '0;
            end else if (frame_tick && !w_hold_done) begin
                r_hcnt <= r_hcnt + c_HONE;
            end
        end
    end

    always_comb begin
        scr_l     = (r_state == c_PULSE) && !r_scorer;
        scr_r     = (r_state == c_PULSE) && r_scorer;
        serve     = r_serve;
        serve_dir = r_serve_dir;
        score_l   = r_score_l;
        score_r   = r_score_r;
        game_over = (r_state == c_OVER);
        winner    = (r_state == c_OVER) && r_scorer;
    end

endmodule
`default_nettype wire

// File: tb/tb_pong_goal_scorer.sv
`default_nettype none
// Testbench for pong_goal_scorer: directed scenarios plus a randomized game
// checked against a goal/score model derived from the scoring rules.
module tb_pong_goal_scorer;

    localparam int P  = 4;
    localparam int H  = 2;
    localparam int M  = 5;
    localparam int LX = 0;
    localparam int RX = 639;
`ifdef AUTO_SERVE_EN
    localparam int AUTO = 1;
`else
    localparam int AUTO = 0;
`endif

    logic       cloco = 1'b0;
    logic       rset;
    logic       frame_tick;
    logic       ball_valid;
    logic [9:0] ball_x;
    logic       serve_btn;
    logic       scr_l, scr_r, serve, serve_dir, game_over, winner;
    logic [2:0] score_l, score_r;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 cloco = ~cloco;

    pong_goal_scorer #(
        .X_WIDTH(10), .LEFT_GOAL_X(LX), .RIGHT_GOAL_X(RX),
        .PULSE_CYCLES(P), .HOLDOFF_FRAMES(H), .MAX_SCORE(M)
    ) dut (
        .cloco(cloco), .rset(rset), .frame_tick(frame_tick), .ball_valid(ball_valid),
        .ball_x(ball_x), .serve_btn(serve_btn), .scr_l(scr_l), .scr_r(scr_r),
        .serve(serve), .serve_dir(serve_dir), .score_l(score_l), .score_r(score_r),
        .game_over(game_over), .winner(winner)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge cloco);
        #1;
    endtask

    task automatic do_reset();
        rset = 1'b1; frame_tick = 1'b0; ball_valid = 1'b0; ball_x = '0; serve_btn = 1'b0;
        step();
        step();
        rset = 1'b0;
        step();
    endtask

    task automatic frame(input logic v, input logic [9:0] x, input logic t);
        frame_tick = t; ball_valid = v; ball_x = x;
        step();
        frame_tick = 1'b0; ball_valid = 1'b0;
    endtask

    task automatic watch(input int n, output int c_l, output int c_r, output int f_l,
                         output int f_r, output int c_sv, output int c_go);
        c_l = 0; c_r = 0; f_l = -1; f_r = -1; c_sv = 0; c_go = 0;
        for (int i = 0; i < n; i++) begin
            if (scr_l) begin if (f_l < 0) f_l = i; c_l++; end
            if (scr_r) begin if (f_r < 0) f_r = i; c_r++; end
            if (serve) c_sv++;
            if (game_over) c_go++;
            step();
        end
    endtask

    task automatic press_serve(output int c_sv);
        int a, b, c, d, e;
        serve_btn = 1'b1;
        watch(3, a, b, c, d, c_sv, e);
        serve_btn = 1'b0;
        step();
    endtask

    task automatic holdoff_then_serve(output int c_sv);
        int a, b, c, d, e, s1, s2;
        frame(1'b0, 10'd300, 1'b1);
        step();
        frame(1'b0, 10'd300, 1'b1);
        watch(3, a, b, c, d, s1, e);
        s2 = 0;
        if (AUTO == 0) press_serve(s2);
        c_sv = s1 + s2;
    endtask

    task automatic test_reset();
        rset = 1'b1; frame_tick = 1'b0; ball_valid = 1'b0; ball_x = '0; serve_btn = 1'b0;
        #3;
        n_checks++;
        if ({scr_l, scr_r, serve, serve_dir, score_l, score_r, game_over, winner} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {scr_l, scr_r, serve, serve_dir, score_l, score_r, game_over, winner});
        end
        do_reset();
    endtask

    task automatic test_serve();
        int c;
        n_checks++;
        if (serve !== 1'b0) begin n_fail++; $display("FAIL serve_idle: got %b expected 0", serve); end
        press_serve(c);
        n_checks++;
        if (c !== 1) begin n_fail++; $display("FAIL serve_width: got %0d cycles expected 1", c); end
        n_checks++;
        if ({score_l, score_r, game_over} !== 7'd0) begin
            n_fail++; $display("FAIL serve_scores: got %b expected 0", {score_l, score_r, game_over});
        end
    endtask

    task automatic test_no_goal();
        int cl, cr, fl, fr, cs, cg, tot;
        tot = 0;
        frame(1'b0, 10'd0, 1'b1);   watch(4, cl, cr, fl, fr, cs, cg); tot += cl + cr;
        frame(1'b1, 10'd0, 1'b0);   watch(4, cl, cr, fl, fr, cs, cg); tot += cl + cr;
        frame(1'b1, 10'd638, 1'b1); watch(4, cl, cr, fl, fr, cs, cg); tot += cl + cr;
        frame(1'b1, 10'd1, 1'b1);   watch(4, cl, cr, fl, fr, cs, cg); tot += cl + cr;
        n_checks++;
        if (tot !== 0) begin n_fail++; $display("FAIL no_goal_strobes: got %0d cycles expected 0", tot); end
        n_checks++;
        if ({score_l, score_r} !== 6'd0) begin
            n_fail++; $display("FAIL no_goal_scores: got %0d/%0d expected 0/0", score_l, score_r);
        end
    endtask

    task automatic test_goal_right();
        int cl, cr, fl, fr, cs, cg;
        frame(1'b1, 10'd0, 1'b1);
        n_checks++;
        if (score_r !== 3'd1) begin n_fail++; $display("FAIL goal_r_score_timing: got %0d expected 1", score_r); end
        watch(8, cl, cr, fl, fr, cs, cg);
        n_checks++;
        if (cr !== P || fr !== 0) begin
            n_fail++; $display("FAIL goal_r_strobe: got %0d cycles from %0d expected %0d from 0", cr, fr, P);
        end
        n_checks++;
        if (cl !== 0) begin n_fail++; $display("FAIL goal_r_other: got %0d expected 0", cl); end
        n_checks++;
        if (serve_dir !== 1'b0 || score_l !== 3'd0) begin
            n_fail++; $display("FAIL goal_r_dir: got dir %b score_l %0d expected 0 0", serve_dir, score_l);
        end
    endtask

    task automatic test_holdoff();
        int cl, cr, fl, fr, cs, cg, c;
        press_serve(c);
        n_checks++;
        if (c !== 0) begin n_fail++; $display("FAIL holdoff_btn_ignored: got %0d expected 0", c); end
        frame(1'b0, 10'd300, 1'b1);
        serve_btn = 1'b1;
        step();
        frame(1'b0, 10'd300, 1'b1);
        watch(4, cl, cr, fl, fr, cs, cg);
        n_checks++;
        if (cs !== AUTO) begin n_fail++; $display("FAIL holdoff_expiry_serve: got %0d expected %0d", cs, AUTO); end
        serve_btn = 1'b0;
        step();
        press_serve(c);
        n_checks++;
        if (c !== 1 - AUTO) begin n_fail++; $display("FAIL holdoff_reserve: got %0d expected %0d", c, 1 - AUTO); end
        frame(1'b1, 10'd639, 1'b1);
        watch(8, cl, cr, fl, fr, cs, cg);
        n_checks++;
        if (cl !== P || cr !== 0 || score_l !== 3'd1 || serve_dir !== 1'b1) begin
            n_fail++;
            $display("FAIL holdoff_play: got l=%0d r=%0d score_l=%0d dir=%b expected %0d 0 1 1",
                     cl, cr, score_l, serve_dir, P);
        end
    endtask

    task automatic test_game_over();
        int cl, cr, fl, fr, cs, cg, c;
        do_reset();
        press_serve(c);
        for (int i = 0; i < M; i++) begin
            frame(1'b1, 10'd639, 1'b1);
            watch(8, cl, cr, fl, fr, cs, cg);
            n_checks++;
            if (cl !== P || fl !== 0 || cr !== 0 || score_l !== 3'(i + 1) || serve_dir !== 1'b1) begin
                n_fail++;
                $display("FAIL over_goal%0d: got l=%0d first=%0d r=%0d score=%0d dir=%b expected %0d 0 0 %0d 1",
                         i, cl, fl, cr, score_l, serve_dir, P, i + 1);
            end
            n_checks++;
            if (cg !== ((i == M - 1) ? 8 - P : 0)) begin
                n_fail++; $display("FAIL over_flag%0d: got %0d cycles expected %0d", i, cg, (i == M - 1) ? 8 - P : 0);
            end
            if (i < M - 1) begin
                holdoff_then_serve(c);
                n_checks++;
                if (c !== 1) begin n_fail++; $display("FAIL over_serve%0d: got %0d expected 1", i, c); end
            end
        end
        n_checks++;
        if (game_over !== 1'b1 || winner !== 1'b0 || score_l !== 3'(M)) begin
            n_fail++; $display("FAIL over_state: got go=%b win=%b score=%0d expected 1 0 %0d",
                               game_over, winner, score_l, M);
        end
        frame(1'b1, 10'd639, 1'b1);
        watch(8, cl, cr, fl, fr, cs, cg);
        press_serve(c);
        n_checks++;
        if (cl + cr + c !== 0 || score_l !== 3'(M) || game_over !== 1'b1) begin
            n_fail++; $display("FAIL over_frozen: got activity=%0d score=%0d go=%b expected 0 %0d 1",
                               cl + cr + c, score_l, game_over, M);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int cl, cr, fl, fr, cs, cg, c;
        do_reset();
        press_serve(c);
        frame(1'b1, 10'd700, 1'b1);
        step();
        n_checks++;
        if (scr_l !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got %b expected 1", scr_l); end
        rset = 1'b1;
        #1;
        n_checks++;
        if (scr_l !== 1'b0 || score_l !== 3'd0 || score_r !== 3'd0) begin
            n_fail++; $display("FAIL midrst_async: got scr_l=%b score_l=%0d expected 0 0", scr_l, score_l);
        end
        #2;
        rset = 1'b0;
        step();
        frame(1'b1, 10'd639, 1'b1);
        watch(8, cl, cr, fl, fr, cs, cg);
        n_checks++;
        if (cl + cr !== 0) begin n_fail++; $display("FAIL midrst_idle: got %0d strobe cycles expected 0", cl + cr); end
        press_serve(c);
        frame(1'b1, 10'd639, 1'b1);
        watch(8, cl, cr, fl, fr, cs, cg);
        n_checks++;
        if (c !== 1 || cl !== P || score_l !== 3'd1) begin
            n_fail++; $display("FAIL midrst_resume: got serve=%0d l=%0d score=%0d expected 1 %0d 1", c, cl, score_l, P);
        end
    endtask

    task automatic test_random();
        int cl, cr, fl, fr, cs, cg, c, k;
        int exp_l, exp_r, exp_dir, exp_win;
        int over;
        logic t, v;
        logic [9:0] x;
        do_reset();
        press_serve(c);
        exp_l = 0; exp_r = 0; exp_dir = 0; over = 0;
        for (int it = 0; it < 80 && over == 0; it++) begin
            t = ($urandom_range(0, 3) != 0);
            v = ($urandom_range(0, 3) != 0);
            k = $urandom_range(0, 2);
            if (k == 0)      x = 10'(LX);
            else if (k == 1) x = 10'($urandom_range(RX, 1023));
            else             x = 10'($urandom_range(LX + 1, RX - 1));
            frame(v, x, t);
            if (t && v && (int'(x) <= LX || int'(x) >= RX)) begin
                if (int'(x) <= LX) begin exp_r++; exp_dir = 0; end
                else begin exp_l++; exp_dir = 1; end
                watch(8, cl, cr, fl, fr, cs, cg);
                n_checks++;
                if ((exp_dir == 0 && (cr !== P || fr !== 0 || cl !== 0)) ||
                    (exp_dir == 1 && (cl !== P || fl !== 0 || cr !== 0))) begin
                    n_fail++; $display("FAIL rand_strobe it%0d: got l=%0d r=%0d expected scorer %0d for %0d cycles",
                                       it, cl, cr, exp_dir, P);
                end
                n_checks++;
                if (score_l !== 3'(exp_l) || score_r !== 3'(exp_r) || serve_dir !== 1'(exp_dir)) begin
                    n_fail++; $display("FAIL rand_score it%0d: got %0d/%0d dir %b expected %0d/%0d dir %0d",
                                       it, score_l, score_r, serve_dir, exp_l, exp_r, exp_dir);
                end
                if (exp_l == M || exp_r == M) begin
                    over = 1;
                    exp_win = (exp_r == M) ? 1 : 0;
                    n_checks++;
                    if (game_over !== 1'b1 || winner !== 1'(exp_win)) begin
                        n_fail++; $display("FAIL rand_over: got go=%b win=%b expected 1 %0d", game_over, winner, exp_win);
                    end
                end else begin
                    holdoff_then_serve(c);
                    n_checks++;
                    if (c !== 1) begin n_fail++; $display("FAIL rand_serve it%0d: got %0d expected 1", it, c); end
                end
            end else begin
                watch(2, cl, cr, fl, fr, cs, cg);
                n_checks++;
                if (cl + cr !== 0 || score_l !== 3'(exp_l) || score_r !== 3'(exp_r)) begin
                    n_fail++; $display("FAIL rand_quiet it%0d: got strobes=%0d scores %0d/%0d expected 0 %0d/%0d",
                                       it, cl + cr, score_l, score_r, exp_l, exp_r);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_no_goal();
        test_goal_right();
        test_holdoff();
        test_game_over();
        test_reset_mid_pulse();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
